// File: rtl/tv80_bus_pkg.sv
// rtl/tv80_bus_pkg.sv - shared T-state enum, command kinds and wait-state selection
package tv80_bus_pkg;

   typedef enum logic [2:0] {
      IDLE,
      T1,
      T2,
      TW,
      T3,
      T4,
      HOLD
   } bus_state_t;

   typedef enum logic [2:0] {
      MEM_RD,
      MEM_WR,
      IO_RD,
      IO_WR,
      M1,
      INTA
   } cmd_kind_t;

   // cmd_wr is meaningless on an M1 cycle, so it is dropped before it can select a write
   function automatic cmd_kind_t decode_kind(input logic m1, input logic io, input logic wr);
      cmd_kind_t k;
      if (m1 && io)  k = INTA;
      else if (m1)   k = M1;
      else if (io)   k = wr ? IO_WR : IO_RD;
      else           k = wr ? MEM_WR : MEM_RD;
      return k;
   endfunction

   function automatic logic is_m1_class(input cmd_kind_t k);
      return (k == M1) || (k == INTA);
   endfunction

   function automatic logic is_write(input cmd_kind_t k);
      return (k == MEM_WR) || (k == IO_WR);
   endfunction

   function automatic logic is_io(input cmd_kind_t k);
      return (k == IO_RD) || (k == IO_WR) || (k == INTA);
   endfunction

   // M1 fetches are memory cycles and share the memory wait count
   function automatic logic [2:0] wait_sel(input cmd_kind_t k, input logic [2:0] mem_w,
                                           input logic [2:0] io_w, input logic [2:0] inta_w);
      logic [2:0] w;
      if (k == INTA)       w = inta_w;
      else if (is_io(k))   w = io_w;
      else                 w = mem_w;
      return w;
   endfunction

endpackage

// File: rtl/tv80_waitcnt.sv
// rtl/tv80_waitcnt.sv - 3-bit load/decrement wait-state counter with zero flag
module tv80_waitcnt (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [2:0] load_val,
   input  logic       dec,
   output logic       zero
);

   logic [2:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != 3'd0)) begin
         cnt <= cnt - 3'd1;
      end
   end

   assign zero = (cnt == 3'd0);

endmodule

// File: rtl/tv80_busctl.sv
// rtl/tv80_busctl.sv - Z80-style T-state bus cycle sequencer with auto waits and bus hold
module tv80_busctl
   import tv80_bus_pkg::*;
#(
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 8,
   parameter int MEM_WAIT  = 0,
   parameter int IO_WAIT   = 1,
   parameter int INTA_WAIT = 2,
   parameter int T2WRITE   = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   output logic              rdy,
   input  logic              cmd_m1,
   input  logic              cmd_io,
   input  logic              cmd_wr,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   input  logic [ADDR_W-1:0] rfsh_addr,
   output logic              done,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] A,
   output logic [DATA_W-1:0] dout,
   input  logic [DATA_W-1:0] di,
   output logic              m1_n,
   output logic              mreq_n,
   output logic              iorq_n,
   output logic              rd_n,
   output logic              wr_n,
   output logic              rfsh_n,
   input  logic              wait_n,
   input  logic              busrq_n,
   output logic              busak_n
);

   localparam logic EARLY_WR = (T2WRITE != 0);

   bus_state_t  state, state_nx, after_cmd;
   cmd_kind_t   kind, kind_in, kind_nx;
   logic        at_final, accept, cnt_zero, capture;
   logic [2:0]  wait_load;

   logic              m1_nx, mreq_nx, iorq_nx, rd_nx, wr_nx, rfsh_nx, busak_nx, done_nx;
   logic [ADDR_W-1:0] a_nx;
   logic [DATA_W-1:0] dout_nx;

   assign kind_in   = decode_kind(cmd_m1, cmd_io, cmd_wr);
   assign wait_load = wait_sel(kind_in, 3'(MEM_WAIT), 3'(IO_WAIT), 3'(INTA_WAIT));

   // M1-class cycles finish in T4 (refresh), all others in T3
   assign at_final = (state == T4) || ((state == T3) && !is_m1_class(kind));
   assign rdy      = busrq_n && ((state == IDLE) || at_final);
   assign accept   = req && rdy;
   assign kind_nx  = accept ? kind_in : kind;

   assign after_cmd = !busrq_n ? HOLD : (req ? T1 : IDLE);

   tv80_waitcnt u_waitcnt (
      .clk      (clk),
      .reset    (reset),
      .load     (accept),
      .load_val (wait_load),
      .dec      (state_nx == TW),
      .zero     (cnt_zero)
   );

   // wait_n only matters once the automatic waits have been used up
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = after_cmd;
         T1:      state_nx = T2;
         T2, TW:  state_nx = (!cnt_zero || !wait_n) ? TW : T3;
         T3:      state_nx = is_m1_class(kind) ? T4 : after_cmd;
         T4:      state_nx = after_cmd;
         HOLD:    state_nx = busrq_n ? IDLE : HOLD;
         default: state_nx = IDLE;
      endcase
   end

   assign capture = ((state == T2) || (state == TW)) && (state_nx == T3) && !is_write(kind);

   // Bus outputs are computed for the state being entered so they can be registered
   always_comb begin
      m1_nx    = 1'b1;
      mreq_nx  = 1'b1;
      iorq_nx  = 1'b1;
      rd_nx    = 1'b1;
      wr_nx    = 1'b1;
      rfsh_nx  = 1'b1;
      busak_nx = 1'b1;
      done_nx  = 1'b0;
      a_nx     = A;
      dout_nx  = dout;
      case (state_nx)
         T1: begin
            a_nx  = cmd_addr;
            m1_nx = !is_m1_class(kind_nx);
            if (is_write(kind_nx)) dout_nx = cmd_wdata;
         end
         T2, TW: begin
            case (kind_nx)
               MEM_RD: begin mreq_nx = 1'b0; rd_nx = 1'b0; end
               IO_RD:  begin iorq_nx = 1'b0; rd_nx = 1'b0; end
               MEM_WR: begin mreq_nx = 1'b0; wr_nx = !((state_nx == TW) || EARLY_WR); end
               IO_WR:  begin iorq_nx = 1'b0; wr_nx = !((state_nx == TW) || EARLY_WR); end
               M1:     begin m1_nx = 1'b0; mreq_nx = 1'b0; rd_nx = 1'b0; end
               INTA:   begin m1_nx = 1'b0; iorq_nx = 1'b0; end
               default: ;
            endcase
         end
         T3: begin
            done_nx = 1'b1;
            if (is_m1_class(kind_nx)) begin
               a_nx    = rfsh_addr;
               rfsh_nx = 1'b0;
               mreq_nx = 1'b0;
            end else if (is_write(kind_nx)) begin
               wr_nx = 1'b0;
               if (is_io(kind_nx)) iorq_nx = 1'b0;
               else                mreq_nx = 1'b0;
            end
         end
         T4: begin
            a_nx    = rfsh_addr;
            rfsh_nx = 1'b0;
         end
         HOLD:    busak_nx = 1'b0;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         kind    <= MEM_RD;
         A       <= '0;
         dout    <= '0;
         rdata   <= '0;
         done    <= 1'b0;
         m1_n    <= 1'b1;
         mreq_n  <= 1'b1;
         iorq_n  <= 1'b1;
         rd_n    <= 1'b1;
         wr_n    <= 1'b1;
         rfsh_n  <= 1'b1;
         busak_n <= 1'b1;
      end else begin
         state   <= state_nx;
         kind    <= kind_nx;
         A       <= a_nx;
         dout    <= dout_nx;
         done    <= done_nx;
         m1_n    <= m1_nx;
         mreq_n  <= mreq_nx;
         iorq_n  <= iorq_nx;
         rd_n    <= rd_nx;
         wr_n    <= wr_nx;
         rfsh_n  <= rfsh_nx;
         busak_n <= busak_nx;
         if (capture) rdata <= di;
      end
   end

endmodule
